// File: rtl/beta_pkg.sv
// ----------------------------------------------------------------------------
// beta_pkg
// Shared constants and types for the pipelined Beta register file.
//   BETA_DATA_W     : register width (the Beta is 32-bit only)
//   BETA_NREGS      : architectural register count, including R31
//   BETA_R31        : address of the hard-wired zero register
//   regfile_state_t : register-file clear sequencer state (CLEAR, RUN)
// ----------------------------------------------------------------------------
package beta_pkg;

    localparam int         BETA_DATA_W = 32;
    localparam int         BETA_NREGS  = 32;
    localparam logic [4:0] BETA_R31    = 5'd31;

    typedef enum logic {
        CLEAR,
        RUN
    } regfile_state_t;

endpackage : beta_pkg

// File: rtl/beta_regfile_clr.sv
// ----------------------------------------------------------------------------
// beta_regfile_clr
// Post-reset clear sequencer for the Beta register file. While in CLEAR it
// walks cnt from R0 to R30, requesting one zero-write per cycle, then moves
// to RUN. Sampling reset high at any time restarts the walk from R0.
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   synchronous, active-high; restarts the clear sequence
//   busy     out  reset OR clear in progress; pipeline must stall
//   clr_we   out  zero-write request for clr_addr this cycle
//   clr_addr out  register being cleared this cycle
// ----------------------------------------------------------------------------
module beta_regfile_clr
    import beta_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic       busy,
    output logic       clr_we,
    output logic [4:0] clr_addr
);

    localparam logic [4:0] LAST_REG = BETA_R31 - 5'd1;

    regfile_state_t state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;

    // NOTE: every variable assigned in always_comb gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_REG) begin
                state_d = RUN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset itself counts as busy so the stall is raised in the very cycle
    // reset is asserted, before the state register has been reloaded.
    assign busy     = reset || (state_q == CLEAR);
    assign clr_we   = !reset && (state_q == CLEAR);
    assign clr_addr = cnt_q;

endmodule : beta_regfile_clr

// File: rtl/beta_regfile.sv
// ----------------------------------------------------------------------------
// beta_regfile
// Three-port register file for the pipelined Beta: two combinational read
// ports and one synchronous write port. R31 is not stored, reads as zero and
// ignores writes. After reset a sequencer zeroes R0-R30, one per cycle, and
// holds busy high; reads return zero and external writes are dropped while
// busy.
//
// Build option
//   BETA_REGFILE_BYPASS_EN : when defined, a read of the register being
//                            written this cycle returns wd (write-through).
//                            When undefined, it returns the pre-write value.
//
// Ports
//   clk    in   single clock, rising edge
//   reset  in   synchronous, active-high; restarts the clear sequence
//   ra1    in   read address, port 1
//   ra2    in   read address, port 2
//   rd1    out  read data, port 1
//   rd2    out  read data, port 2
//   we     in   write enable
//   wa     in   write address (31 = no write)
//   wd     in   write data
//   busy   out  clear sequence in progress; pipeline must stall
// ----------------------------------------------------------------------------
module beta_regfile
    import beta_pkg::*;
#(
    parameter int DATA_W = BETA_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    output logic              busy
);

    localparam int NSTORED = BETA_NREGS - 1;

    logic              clr_we;
    logic [4:0]        clr_addr;
    logic              ext_we;

    logic [DATA_W-1:0] regs_q [NSTORED];
    logic [DATA_W-1:0] regs_d [NSTORED];

    beta_regfile_clr u_clr (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // External writes are masked while busy, so the clear port never
    // competes with them; giving it priority below is only for clarity.
    assign ext_we = we && !busy && (wa != BETA_R31);

    always_comb begin
        regs_d = regs_q;
        if (clr_we) begin
            regs_d[clr_addr] = '0;
        end else if (ext_we) begin
            regs_d[wa] = wd;
        end
    end

    // NOTE: the storage array has no reset branch; the clear sequencer
    // rewrites every register after reset, so a reset here would only add
    // a wide reset fan-out for no functional gain.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] ra);
        logic [DATA_W-1:0] val;
        val = '0;
        if (!busy && (ra != BETA_R31)) begin
            val = regs_q[ra];
`ifdef BETA_REGFILE_BYPASS_EN
            if (ext_we && (wa == ra)) begin
                val = wd;
            end
`endif
        end
        return val;
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

endmodule : beta_regfile

// File: tb/tb_beta_regfile.sv
// ----------------------------------------------------------------------------
// tb_beta_regfile
// Self-checking bench for beta_regfile. A behavioural model (a plain array of
// 32 words plus the bypass rule) predicts every read; randomized traffic is
// mixed with directed reset, R31, busy-masking and same-cycle RAW scenarios.
// ----------------------------------------------------------------------------
module tb_beta_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [32];

    beta_regfile dut (
        .clk   (clk),
        .reset (reset),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read value for the current (non-busy) cycle's inputs.
    function automatic logic [31:0] expect_rd(input logic [4:0] ra);
        if (ra == 5'd31) return 32'h0;
`ifdef BETA_REGFILE_BYPASS_EN
        if (we && wa != 5'd31 && wa == ra) return wd;
`endif
        return model[ra];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        we = 1'b1;
        wa = addr;
        wd = data;
        tick();
        if (addr != 5'd31) model[addr] = data;
        we = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] addr);
        ra1 = addr;
        ra2 = addr;
        #1;
        check($sformatf("%s_rd1_r%0d", tag, addr), rd1, expect_rd(addr));
        check($sformatf("%s_rd2_r%0d", tag, addr), rd2, expect_rd(addr));
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 32; i++) read_chk(tag, 5'(i));
    endtask

    // Counts negedge samples with busy high, bounded so a stuck busy ends
    // as a wrong count rather than a hang. Returns aligned after a posedge.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        tick();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    int          nbusy;
    logic [31:0] exp1, exp2;

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        wa    = 5'd0;
        wd    = 32'h0;
        ra1   = 5'd0;
        ra2   = 5'd0;

        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'h1);
        check("reset_rd1", rd1, 32'h0);
        check("reset_rd2", rd2, 32'h0);
        tick();

        // First clear: exactly 31 busy cycles after release.
        reset = 1'b0;
        count_busy(nbusy);
        check("clear_len", nbusy, 32'd31);
        model_clear();

        // Preload DEADBEEF everywhere, then reset and confirm full clear.
        for (int i = 0; i < 32; i++) write_reg(5'(i), 32'hDEADBEEF);
        read_all("preload");
        do_reset(3);
        count_busy(nbusy);
        check("clear_len2", nbusy, 32'd31);
        model_clear();
        read_all("cleared");

        // Basic write/read, both ports on the same address.
        write_reg(5'd5, 32'h12345678);
        read_chk("basic", 5'd5);
        check("basic_abs", rd1, 32'h12345678);

        // R31 ignores writes and reads zero; nothing else changes.
        write_reg(5'd31, 32'hFFFFFFFF);
        read_all("r31");

        // Same-cycle RAW on R7.
        write_reg(5'd7, 32'h1);
        we  = 1'b1;
        wa  = 5'd7;
        wd  = 32'h2;
        ra1 = 5'd7;
        #1;
`ifdef BETA_REGFILE_BYPASS_EN
        check("raw_same", rd1, 32'h2);
`else
        check("raw_same", rd1, 32'h1);
`endif
        tick();
        model[7] = 32'h2;
        we = 1'b0;
        #1;
        check("raw_next", rd1, 32'h2);

        // Randomized traffic against the model.
        for (int it = 0; it < 400; it++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom();
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
            #1;
            exp1 = expect_rd(ra1);
            exp2 = expect_rd(ra2);
            check($sformatf("rand%0d_rd1", it), rd1, exp1);
            check($sformatf("rand%0d_rd2", it), rd2, exp2);
            tick();
            if (we && wa != 5'd31) model[wa] = wd;
        end
        we = 1'b0;

        // Busy masking: a write during clear cycle 10 is dropped.
        write_reg(5'd3, 32'h0BADF00D);
        do_reset(1);
        repeat (10) tick();
        we  = 1'b1;
        wa  = 5'd3;
        wd  = 32'hA5A5A5A5;
        ra1 = 5'd3;
        ra2 = 5'd3;
        #1;
        check("mask_busy", {31'h0, busy}, 32'h1);
        check("mask_rd_busy", rd1, 32'h0);
        tick();
        we = 1'b0;
        count_busy(nbusy);
        check("mask_rest_len", nbusy, 32'd20);
        model_clear();
        read_chk("mask", 5'd3);
        read_all("mask_all");

        // Mid-clear reset at clear cycle 20 restarts a full 31-cycle clear.
        for (int i = 0; i < 31; i++) write_reg(5'(i), $urandom() | 32'h1);
        do_reset(1);
        repeat (20) tick();
        do_reset(1);
        count_busy(nbusy);
        check("midclr_len", nbusy, 32'd31);
        model_clear();
        read_all("midclr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog: a stall anywhere still ends the run with a report.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_beta_regfile
